// File: rtl/telemetry_tx.sv
// Purpose: encode queued (id, index, value) records into 12-byte ASCII telemetry frames.
// Latency: a record accepted into an empty idle block is popped next edge; byte 0 is valid after that edge.
// Backpressure: tx_valid/tx_data hold while tx_ready is low; req_ready drops when the FIFO is full.
module telemetry_tx #(
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_id,
   input  logic [3:0]    req_index,
   input  logic [15:0]   req_value,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [7:0]    tx_data,
   output logic          busy,
   output logic [CW-1:0] frames_sent
);

   localparam int SWIDTH = 2;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   // S_OFF doubles as the idle state and S_A as the sending state.
   typedef enum logic [SWIDTH-1:0] {
      S_OFF = 2'd0,
      S_A   = 2'd1,
      S_B   = 2'd2,
      S_C   = 2'd3
   } state_t;

   // Record FIFO storage and bookkeeping.
   logic [21:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   // Serializer state.
   state_t        r_state;
   state_t        w_state_nxt;
   logic [21:0]   r_frame;
   logic [3:0]    r_byte_idx;
   logic [7:0]    r_tx_data;
   logic [CW-1:0] r_frames_sent;

   logic          w_push;
   logic          w_pop;
   logic          w_adv;
   logic          w_done;
   logic          w_fifo_ne;
   logic [21:0]   w_head;

   // One uppercase ASCII hex digit.
   function automatic logic [7:0] f_hex(input logic [3:0] n);
      f_hex = (n > 4'd9) ? (8'h37 + {4'h0, n}) : (8'h30 + {4'h0, n});
   endfunction

   // Byte idx of the frame for record fr = {id, index, value}.
   function automatic logic [7:0] f_byte(input logic [21:0] fr, input logic [3:0] idx);
      case (idx)
         4'd0:    f_byte = 8'h75;
         4'd1:    f_byte = 8'h20;
         4'd2:    f_byte = fr[21] ? 8'h31 : 8'h30;
         4'd3:    f_byte = fr[20] ? 8'h31 : 8'h30;
         4'd4:    f_byte = 8'h20;
         4'd5:    f_byte = f_hex(fr[19:16]);
         4'd6:    f_byte = 8'h20;
         4'd7:    f_byte = f_hex(fr[15:12]);
         4'd8:    f_byte = f_hex(fr[11:8]);
         4'd9:    f_byte = f_hex(fr[7:4]);
         4'd10:   f_byte = f_hex(fr[3:0]);
         default: f_byte = 8'h0A;
      endcase
   endfunction

   assign req_ready   = (r_count != CNT_FULL);
   assign w_push      = req_valid && req_ready;
   assign w_fifo_ne   = (r_count != '0);
   assign w_head      = r_mem[r_rptr];
   assign tx_valid    = (r_state == S_A);
   assign tx_data     = r_tx_data;
   assign busy        = (r_state == S_A) || w_fifo_ne;
   assign frames_sent = r_frames_sent;

   // FIFO storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {req_id, req_index, req_value};
      end
   end

   // FIFO pointers and occupancy; a full FIFO never pushes even if popping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_OFF;
      else     r_state <= w_state_nxt;
   end

   // Next state and datapath strobes; the last byte reloads directly when more records wait.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_adv       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_OFF: begin
            if (w_fifo_ne) begin
               w_pop       = 1'b1;
               w_state_nxt = S_A;
            end
         end
         S_A: begin
            if (tx_ready) begin
               if (r_byte_idx == 4'd11) begin
                  w_done = 1'b1;
                  if (w_fifo_ne) w_pop       = 1'b1;
                  else           w_state_nxt = S_OFF;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_OFF;
      endcase
   end

   // Frame holding register, byte index, registered output byte and frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame       <= '0;
         r_byte_idx    <= '0;
         r_tx_data     <= 8'h00;
         r_frames_sent <= '0;
      end else begin
         if (w_pop) begin
            r_frame    <= w_head;
            r_byte_idx <= 4'd0;
            r_tx_data  <= 8'h75;
         end else if (w_adv) begin
            r_byte_idx <= r_byte_idx + 4'd1;
            r_tx_data  <= f_byte(r_frame, r_byte_idx + 4'd1);
         end else if (w_done) begin
            r_tx_data  <= 8'h00;
         end
         if (w_done) r_frames_sent <= r_frames_sent + 1'b1;
      end
   end

endmodule

// File: tb/tb_telemetry_tx.sv
// Purpose: scoreboard bench for telemetry_tx; expected bytes queued at push, checked by a monitor.
// Latency: monitor compares each byte at the negedge before the transfer edge.
// Backpressure: bench drives tx_ready patterns and checks held bytes stay stable.
module tb_telemetry_tx;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_id;
   logic [3:0]  req_index;
   logic [15:0] req_value;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        busy;
   logic [7:0]  frames_sent;

   telemetry_tx #(.DEPTH(4), .CW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_id      (req_id),
      .req_index   (req_index),
      .req_value   (req_value),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   int         n_checks = 0;
   int         n_bad    = 0;
   int         cyc      = 0;
   int         xfer_cnt = 0;
   int         first_xfer = -1;
   int         last_xfer  = -1;
   int         acc_cyc  = 0;
   logic [7:0] exp_q [$];
   logic       hold_pend = 1'b0;
   logic [7:0] hold_dat  = 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] hx(input logic [3:0] n);
      hx = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'h0A);
   endfunction

   function automatic logic [7:0] enc(input logic [1:0] id, input logic [3:0] ix,
                                      input logic [15:0] v, input int k);
      logic [7:0] b [12];
      b[0] = 8'h75; b[1] = 8'h20;
      b[2] = id[1] ? 8'h31 : 8'h30;
      b[3] = id[0] ? 8'h31 : 8'h30;
      b[4] = 8'h20; b[5] = hx(ix); b[6] = 8'h20;
      b[7] = hx(v[15:12]); b[8] = hx(v[11:8]); b[9] = hx(v[7:4]); b[10] = hx(v[3:0]);
      b[11] = 8'h0A;
      enc = b[k];
   endfunction

   task automatic push_exp(input logic [1:0] id, input logic [3:0] ix, input logic [15:0] v);
      for (int k = 0; k < 12; k++) exp_q.push_back(enc(id, ix, v, k));
   endtask

   // Offer one record and wait for it to be accepted; optionally queue the model frame.
   task automatic push(input logic [1:0] id, input logic [3:0] ix, input logic [15:0] v,
                       input bit model);
      bit ok = 1'b0;
      req_valid = 1'b1; req_id = id; req_index = ix; req_value = v;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      chk("push_accept_timeout", 32'(ok), 32'd1);
      if (ok && model) push_exp(id, ix, v);
      @(posedge clk); #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic clear_stats();
      xfer_cnt = 0; first_xfer = -1; last_xfer = -1;
   endtask

   // Monitor: compare every transferred byte with the scoreboard and check hold stability.
   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(hold_dat));
         end
         hold_pend = tx_valid && !tx_ready;
         hold_dat  = tx_data;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (xfer_cnt == 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_cnt++;
         end
      end
   end

   initial begin
      logic [7:0] v1 [12];
      logic [7:0] v2 [12];
      int         acc;
      int         base;
      bit         r_t;
      v1 = '{8'h75, 8'h20, 8'h30, 8'h31, 8'h20, 8'h33, 8'h20, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0A};
      v2 = '{8'h75, 8'h20, 8'h31, 8'h30, 8'h20, 8'h46, 8'h20, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
      rst = 1'b1; req_valid = 1'b0; req_id = '0; req_index = '0; req_value = '0; tx_ready = 1'b1;

      // Reset state.
      #1;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frames", 32'(frames_sent), 32'd0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // Single frame, hand-computed bytes.
      clear_stats();
      for (int k = 0; k < 12; k++) exp_q.push_back(v1[k]);
      push(2'b01, 4'h3, 16'h00FF, 1'b0);
      drain();
      chk("t1_first_latency", 32'(first_xfer - acc_cyc), 32'd1);
      chk("t1_span", 32'(last_xfer - first_xfer), 32'd11);
      chk("t1_count", 32'(xfer_cnt), 32'd12);
      chk("t1_frames", 32'(frames_sent), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_tx_valid", 32'(tx_valid), 32'd0);

      // Hex letters, hand-computed bytes.
      clear_stats();
      for (int k = 0; k < 12; k++) exp_q.push_back(v2[k]);
      push(2'b10, 4'hF, 16'hABCD, 1'b0);
      drain();
      chk("t2_count", 32'(xfer_cnt), 32'd12);
      chk("t2_frames", 32'(frames_sent), 32'd2);

      // Backpressure: tx_ready alternates 1,0,... from the first valid cycle.
      tx_ready = 1'b0;
      clear_stats();
      push(2'b00, 4'h5, 16'h1234, 1'b1);
      r_t = 1'b1;
      repeat (24) begin
         @(posedge clk); #1;
         tx_ready = r_t;
         r_t = ~r_t;
      end
      tx_ready = 1'b1;
      drain();
      chk("t3_count", 32'(xfer_cnt), 32'd12);
      chk("t3_span", 32'(last_xfer - first_xfer), 32'd22);
      chk("t3_frames", 32'(frames_sent), 32'd3);

      // Full FIFO plus holding register, then back-to-back frames.
      tx_ready = 1'b0;
      clear_stats();
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_id    = 2'(i % 3);
         req_index = 4'(i + 6);
         req_value = 16'hC0A0 + 16'(i * 16'h0111);
         @(negedge clk);
         if (req_ready) begin
            acc++;
            push_exp(req_id, req_index, req_value);
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("t4_accepted", 32'(acc), 32'd5);
      chk("t4_req_ready_full", 32'(req_ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      tx_ready = 1'b1;
      drain();
      chk("t4_count", 32'(xfer_cnt), 32'd60);
      chk("t4_no_bubble", 32'(last_xfer - first_xfer), 32'd59);
      chk("t4_frames", 32'(frames_sent), 32'd8);

      // Reset mid-frame, byte 6 presented, two records still queued.
      tx_ready = 1'b0;
      push(2'b01, 4'h1, 16'h1111, 1'b1);
      push(2'b10, 4'h2, 16'h2222, 1'b1);
      push(2'b00, 4'h3, 16'h3333, 1'b1);
      tx_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 tx_ready = 1'b0;
      chk("t5_queued_left", 32'(exp_q.size()), 32'd30);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_frames", 32'(frames_sent), 32'd0);
      chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("t5_req_ready", 32'(req_ready), 32'd1);
      chk("t5_idle", 32'(tx_valid), 32'd0);
      tx_ready = 1'b1;
      clear_stats();
      push(2'b11, 4'hA, 16'h0F0F, 1'b1);
      drain();
      chk("t5_count", 32'(xfer_cnt), 32'd12);
      chk("t5_frames", 32'(frames_sent), 32'd1);

      // Counter wrap: 256 frames from a fresh reset, then one more.
      #2 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      clear_stats();
      for (int i = 0; i < 256; i++) begin
         push(2'(i), 4'(i), 16'(i * 7), 1'b1);
      end
      drain();
      chk("t6_count", 32'(xfer_cnt), 32'd3072);
      chk("t6_wrap0", 32'(frames_sent), 32'd0);
      base = xfer_cnt;
      push(2'b01, 4'h7, 16'hBEEF, 1'b1);
      drain();
      chk("t6_wrap1", 32'(frames_sent), 32'd1);
      chk("t6_count2", 32'(xfer_cnt - base), 32'd12);
      chk("t6_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
